aes_round_ctrl: RTL and testbench
=================================

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter NUM_ROUNDS, default 10, meaning cipher rounds per block, legal range 1..15.
REQ-002 Parameter KEY_TIMEOUT, default 24, meaning max cycles in KEY_WAIT before key_err.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 key_valid  input  1  new 128-bit key present at round-key generator input.
REQ-006 key_ready  output  1  controller accepts key; transfer when key_valid & key_ready.
REQ-007 key_done  input  1  round-key generator reports expansion complete.
REQ-008 chg_key  output  1  load/expand command to round-key generator.
REQ-009 blk_valid  input  1  plaintext block present; blk_ready  output  1  block accepted when both high.
REQ-010 out_ready  input  1  consumer accepts result; out_valid  output  1  ciphertext valid.
REQ-011 cur_round  output  4  round index to round-key generator and round datapath.
REQ-012 pre_add_en  output  1  initial AddRoundKey strobe; round_en  output  1  full-round strobe; skip_mix  output  1  final round, bypass MixColumns.
REQ-013 busy  output  1  state not IDLE/READY; key_loaded  output  1  valid expanded key held; key_err  output  1  sticky expansion timeout.

Function
REQ-014 FSM states SHALL be IDLE, KEY_LOAD, KEY_WAIT, READY, PRE_ADD, ROUND, DONE; all outputs registered or decoded from state/counters only, except key_ready in READY (REQ-019).
REQ-015 IDLE: key_ready=1, blk_ready=0; key handshake -> KEY_LOAD; blk_valid ignored.
REQ-016 KEY_LOAD: one cycle, chg_key=1, key_loaded cleared, wait counter cleared; -> KEY_WAIT.
REQ-017 KEY_WAIT: chg_key=1; key_done=1 -> READY with key_loaded=1, chg_key=0 next cycle; counter reaching KEY_TIMEOUT without key_done -> IDLE, key_err=1.
REQ-018 key_err SHALL stay set until rst or next accepted key handshake.
REQ-019 READY: blk_ready=1, key_ready=~blk_valid; simultaneous key_valid & blk_valid -> block accepted, key stalled; block handshake -> PRE_ADD; key handshake -> KEY_LOAD.
REQ-020 PRE_ADD: one cycle, pre_add_en=1, cur_round=0; -> ROUND with cur_round=1.
REQ-021 ROUND: round_en=1 each cycle; cur_round increments by 1 per cycle; skip_mix=1 only when cur_round==NUM_ROUNDS; after that cycle -> DONE.
REQ-022 DONE: out_valid=1, cur_round held at NUM_ROUNDS, blk_ready=0, key_ready=0; out_ready=1 -> READY next cycle; out_valid SHALL not drop before out_ready.
REQ-023 Latency: block accepted in cycle T -> pre_add_en at T+1, round_en T+2..T+1+NUM_ROUNDS, out_valid first at T+2+NUM_ROUNDS (T+12 default).
REQ-024 cur_round SHALL read 0 in IDLE, KEY_LOAD, KEY_WAIT, READY; never exceeds NUM_ROUNDS; no wrap.
REQ-025 pre_add_en, round_en, chg_key mutually exclusive; at most one high per cycle.
REQ-026 key_valid, key_done, blk_valid outside their accepting states SHALL have no effect.
REQ-027 busy=1 in KEY_LOAD, KEY_WAIT, PRE_ADD, ROUND, DONE.

Reset
REQ-028 rst=1 at any clock edge, including mid-expansion or mid-round, SHALL force IDLE next cycle: cur_round=0, chg_key=0, pre_add_en=0, round_en=0, skip_mix=0, out_valid=0, blk_ready=0, busy=0, key_loaded=0, key_err=0, key_ready=1.
REQ-029 Reset SHALL discard any in-flight block; no out_valid produced for it.

Verification
REQ-030 Key load: key_valid pulse in IDLE, key_done 11 cycles later -> chg_key high 12 cycles, then READY, key_loaded=1, blk_ready=1.
REQ-031 Encrypt: block accepted cycle T, out_ready=1 -> pre_add_en T+1 (round 0), round_en T+2..T+11 (rounds 1..10), skip_mix only T+11, out_valid T+12 for one cycle.
REQ-032 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and cur_round=10 stable, blk_ready=0; out_ready=1 -> READY next cycle.
REQ-033 Collision: key_valid & blk_valid same cycle in READY -> key_ready=0, block processed; key accepted on first READY cycle after DONE.
REQ-034 Timeout: key_done never asserted -> key_err=1 and IDLE after 24 KEY_WAIT cycles; next key handshake clears key_err.
REQ-035 Mid-op reset: rst at round 5 -> next cycle all outputs at REQ-028 values, no out_valid follows.

Source files
------------

// File: rtl/aes_round_ctrl_if.sv
// Handshake and strobe bundle between the AES round controller and its environment.
// The slave side is the controller; the master side drives keys, blocks and out_ready.
interface aes_round_ctrl_if;
    logic       key_valid;
    logic       key_ready;
    logic       key_done;
    logic       chg_key;
    logic       blk_valid;
    logic       blk_ready;
    logic       out_ready;
    logic       out_valid;
    logic [3:0] cur_round;
    logic       pre_add_en;
    logic       round_en;
    logic       skip_mix;
    logic       busy;
    logic       key_loaded;
    logic       key_err;

    modport master (
        output key_valid, key_done, blk_valid, out_ready,
        input  key_ready, chg_key, blk_ready, out_valid, cur_round,
               pre_add_en, round_en, skip_mix, busy, key_loaded, key_err
    );

    modport slave (
        input  key_valid, key_done, blk_valid, out_ready,
        output key_ready, chg_key, blk_ready, out_valid, cur_round,
               pre_add_en, round_en, skip_mix, busy, key_loaded, key_err
    );
endinterface

// File: rtl/aes_round_ctrl.sv
// Sequencer for an iterative AES datapath: key expansion handshake, initial
// AddRoundKey, NUM_ROUNDS full rounds (last one without MixColumns), result hold.
module aes_round_ctrl #(
    parameter int NUM_ROUNDS  = 10,
    parameter int KEY_TIMEOUT = 24
) (
    input  logic           clk,
    input  logic           rst,
    aes_round_ctrl_if.slave bus
);
    localparam int WW = (KEY_TIMEOUT < 2) ? 1 : $clog2(KEY_TIMEOUT + 1);
    localparam logic [3:0]    LAST_ROUND = 4'(NUM_ROUNDS);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(KEY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_KEY_LOAD, S_KEY_WAIT, S_READY, S_PRE_ADD, S_ROUND, S_DONE
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [3:0]    r_round, w_round_nxt;
    logic [WW-1:0] r_wait,  w_wait_nxt;
    logic          r_key_loaded, w_key_loaded_nxt;
    logic          r_key_err,    w_key_err_nxt;
    logic          w_last_round;

    assign w_last_round = (r_round == LAST_ROUND);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_round      <= '0;
            r_wait       <= '0;
            r_key_loaded <= 1'b0;
            r_key_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_round      <= w_round_nxt;
            r_wait       <= w_wait_nxt;
            r_key_loaded <= w_key_loaded_nxt;
            r_key_err    <= w_key_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_round_nxt      = r_round;
        w_wait_nxt       = r_wait;
        w_key_loaded_nxt = r_key_loaded;
        w_key_err_nxt    = r_key_err;
        case (r_state)
            S_IDLE: begin
                if (bus.key_valid) begin
                    w_state_nxt      = S_KEY_LOAD;
                    w_key_loaded_nxt = 1'b0;
                    w_key_err_nxt    = 1'b0;
                end
            end
            S_KEY_LOAD: begin
                w_wait_nxt       = '0;
                w_key_loaded_nxt = 1'b0;
                w_state_nxt      = S_KEY_WAIT;
            end
            S_KEY_WAIT: begin
                // key_done wins over a timeout landing in the same cycle
                if (bus.key_done) begin
                    w_state_nxt      = S_READY;
                    w_key_loaded_nxt = 1'b1;
                end else if (r_wait == WAIT_LAST) begin
                    w_state_nxt   = S_IDLE;
                    w_key_err_nxt = 1'b1;
                end else begin
                    w_wait_nxt = r_wait + WW'(1);
                end
            end
            S_READY: begin
                if (bus.blk_valid) begin
                    w_state_nxt = S_PRE_ADD;
                    w_round_nxt = '0;
                end else if (bus.key_valid) begin
                    w_state_nxt      = S_KEY_LOAD;
                    w_key_loaded_nxt = 1'b0;
                    w_key_err_nxt    = 1'b0;
                end
            end
            S_PRE_ADD: begin
                w_state_nxt = S_ROUND;
                w_round_nxt = 4'd1;
            end
            S_ROUND: begin
                if (w_last_round) w_state_nxt = S_DONE;
                else              w_round_nxt = r_round + 4'd1;
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = S_READY;
                    w_round_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_round_nxt = '0;
            end
        endcase
    end

    // Block has priority over key in READY, so key_ready looks at blk_valid.
    assign bus.key_ready  = (r_state == S_IDLE) || ((r_state == S_READY) && !bus.blk_valid);
    assign bus.blk_ready  = (r_state == S_READY);
    assign bus.chg_key    = (r_state == S_KEY_LOAD) || (r_state == S_KEY_WAIT);
    assign bus.pre_add_en = (r_state == S_PRE_ADD);
    assign bus.round_en   = (r_state == S_ROUND);
    assign bus.skip_mix   = (r_state == S_ROUND) && w_last_round;
    assign bus.out_valid  = (r_state == S_DONE);
    assign bus.cur_round  = r_round;
    assign bus.busy       = (r_state != S_IDLE) && (r_state != S_READY);
    assign bus.key_loaded = r_key_loaded;
    assign bus.key_err    = r_key_err;
endmodule

// File: tb/tb_aes_round_ctrl.sv
// Randomized bench for aes_round_ctrl: scenario tasks derive every cycle's expected
// outputs from the protocol timeline (handshake cycle, round number, stall count).
module tb_aes_round_ctrl;
    localparam int NR = 10;
    localparam int KT = 24;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_round_ctrl_if bus ();

    aes_round_ctrl #(.NUM_ROUNDS(NR), .KEY_TIMEOUT(KT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic       key_ready;
        logic       chg_key;
        logic       blk_ready;
        logic       out_valid;
        logic [3:0] cur_round;
        logic       pre_add_en;
        logic       round_en;
        logic       skip_mix;
        logic       busy;
        logic       key_loaded;
        logic       key_err;
    } obs_t;

    int n_chk = 0;
    int n_err = 0;
    bit m_kl, m_ke, m_ready;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic obs_t observed();
        obs_t o;
        o.key_ready  = bus.key_ready;
        o.chg_key    = bus.chg_key;
        o.blk_ready  = bus.blk_ready;
        o.out_valid  = bus.out_valid;
        o.cur_round  = bus.cur_round;
        o.pre_add_en = bus.pre_add_en;
        o.round_en   = bus.round_en;
        o.skip_mix   = bus.skip_mix;
        o.busy       = bus.busy;
        o.key_loaded = bus.key_loaded;
        o.key_err    = bus.key_err;
        return o;
    endfunction

    // Expected outputs for a protocol phase, from the per-phase output rules.
    function automatic obs_t expect_ph(input string ph, input int rnd, input bit bv);
        obs_t e = '0;
        e.key_loaded = m_kl;
        e.key_err    = m_ke;
        case (ph)
            "IDLE":  e.key_ready = 1'b1;
            "LOAD", "WAIT": begin e.chg_key = 1'b1; e.busy = 1'b1; end
            "READY": begin e.blk_ready = 1'b1; e.key_ready = !bv; end
            "PRE":   begin e.pre_add_en = 1'b1; e.busy = 1'b1; end
            "ROUND": begin
                e.round_en  = 1'b1;
                e.busy      = 1'b1;
                e.cur_round = 4'(rnd);
                e.skip_mix  = (rnd == NR);
            end
            "DONE":  begin e.out_valid = 1'b1; e.busy = 1'b1; e.cur_round = 4'(NR); end
            default: e = '1;
        endcase
        return e;
    endfunction

    task automatic step(input string tag, input string ph, input int rnd,
                        input bit kv, input bit kd, input bit bv, input bit ordy, input bit r);
        @(negedge clk);
        rst = r;
        bus.key_valid = kv;
        bus.key_done  = kd;
        bus.blk_valid = bv;
        bus.out_ready = ordy;
        #1;
        check_val(tag, 32'(observed()), 32'(expect_ph(ph, rnd, bv)));
    endtask

    function automatic bit rb();
        return bit'($urandom_range(0, 1));
    endfunction

    // k = cycles in key wait until key_done; k > KT means key_done never comes.
    task automatic key_load(input int k);
        step("key_hs", m_ready ? "READY" : "IDLE", 0, 1'b1, rb(), 1'b0, rb(), 1'b0);
        m_kl = 1'b0;
        m_ke = 1'b0;
        step("key_load", "LOAD", 0, rb(), rb(), rb(), rb(), 1'b0);
        if (k <= KT) begin
            for (int i = 1; i <= k; i++)
                step("key_wait", "WAIT", 0, rb(), (i == k), rb(), rb(), 1'b0);
            m_kl    = 1'b1;
            m_ready = 1'b1;
        end else begin
            for (int i = 1; i <= KT; i++)
                step("key_tmo", "WAIT", 0, rb(), 1'b0, rb(), rb(), 1'b0);
            m_ke    = 1'b1;
            m_ready = 1'b0;
        end
    endtask

    // rst_at = round during which reset is applied (0 = none).
    task automatic encrypt(input bit collide, input int stall, input int rst_at);
        step(collide ? "blk_collide" : "blk_hs", "READY", 0, collide, rb(), 1'b1, rb(), 1'b0);
        step("pre_add", "PRE", 0, rb(), rb(), rb(), rb(), 1'b0);
        for (int r = 1; r <= NR; r++) begin
            step("round", "ROUND", r, rb(), rb(), rb(), rb(), (r == rst_at));
            if (r == rst_at) begin
                m_kl    = 1'b0;
                m_ke    = 1'b0;
                m_ready = 1'b0;
                for (int i = 0; i < NR + 3; i++)
                    step("rst_idle", "IDLE", 0, 1'b0, rb(), rb(), rb(), 1'b0);
                return;
            end
        end
        for (int s = 0; s <= stall; s++)
            step(s < stall ? "done_stall" : "done", "DONE", NR, rb(), rb(), rb(), (s == stall), 1'b0);
        step("ready_after", "READY", 0, 1'b0, rb(), 1'b0, rb(), 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        bus.key_valid = 1'b0;
        bus.key_done  = 1'b0;
        bus.blk_valid = 1'b0;
        bus.out_ready = 1'b0;
        m_kl = 1'b0; m_ke = 1'b0; m_ready = 1'b0;
        repeat (2) @(negedge clk);
        step("reset", "IDLE", 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++)
            step("idle_noise", "IDLE", 0, 1'b0, 1'b1, 1'b1, rb(), 1'b0);

        key_load(11);
        encrypt(1'b0, 0, 0);
        encrypt(1'b1, 5, 0);
        key_load(3);
        encrypt(1'b0, 0, 5);
        key_load(KT + 6);
        step("tmo_idle", "IDLE", 0, 1'b0, 1'b1, 1'b1, rb(), 1'b0);
        key_load(4);
        encrypt(1'b0, 2, 0);
        key_load(KT);
        encrypt(1'b0, 0, NR);
        key_load(1);
        encrypt(1'b0, 0, 1);

        for (int it = 0; it < 20; it++) begin
            if (!m_ready) begin
                key_load(int'($urandom_range(1, KT + 4)));
            end else begin
                case ($urandom_range(0, 3))
                    0: key_load(int'($urandom_range(1, KT + 4)));
                    1: encrypt(rb(), 0, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, NR)) : 0);
                    2: encrypt(rb(), int'($urandom_range(0, 6)), 0);
                    default:
                        for (int i = 0; i < 3; i++)
                            step("ready_idle", "READY", 0, 1'b0, rb(), 1'b0, rb(), 1'b0);
                endcase
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1);
    end
endmodule
